// File: rtl/tt_um_uart_transmitter.sv
// UART transmit engine: serializes one byte per valid/ready handshake into
// start bit, DATA_BITS data bits LSB-first, optional parity bit, STOP_BITS stop bits.
//
// Optional feature macro: UART_PARITY_EN (compiles in the PARITY state and parity bit).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ena        active-high enable; low freezes divider, bit counter, FSM and tx
//   data_in    byte to send, latched on accept (only [DATA_BITS-1:0] used)
//   valid_in   data_in is valid
//   ready_out  can accept a byte this cycle (combinational from state)
//   tx         registered serial output, idle high
//   busy       frame in progress
module tt_um_uart_transmitter #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
  localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

  // Elaboration-time parameter legality check.
  if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_params
    $error("tt_um_uart_transmitter: illegal parameter value");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic            par_q, par_d;
`endif

  logic accept;
  logic wrap;

  assign ready_out = (state_q == StIdle) & ena & ~rst;
  assign accept    = valid_in & ready_out;
  assign busy      = (state_q != StIdle);
  assign tx        = tx_q;
  assign wrap      = (div_q == DivMax);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    // Divider free-runs while a frame is in progress; bit advance happens on wrap.
    if (state_q != StIdle) begin
      div_d = wrap ? '0 : div_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        tx_d  = 1'b1;
        div_d = '0;
        if (accept) begin
          state_d                  = StStart;
          shift_d                  = '0;
          shift_d[DATA_BITS-1:0]   = data_in[DATA_BITS-1:0];
`ifdef UART_PARITY_EN
          par_d = (^data_in[DATA_BITS-1:0]) ^ 1'(PARITY_ODD);
`endif
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (wrap) state_d = StData;
      end
      StData: begin
        tx_d = shift_q[0];
        if (wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == LastData) begin
            bit_d = '0;
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        tx_d = par_q;
        if (wrap) state_d = StStop;
      end
`endif
      StStop: begin
        tx_d = 1'b1;
        // Bit counter is reused to count stop-bit periods.
        if (wrap) begin
          if (bit_q == LastStop) begin
            bit_d   = '0;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (ena) begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_tt_um_uart_transmitter.sv
module tb_tt_um_uart_transmitter;

`ifdef UART_PARITY_EN
  localparam bit UsePar = 1'b1;
`else
  localparam bit UsePar = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, ena, valid1, valid2;
  logic [7:0] data_in;
  logic       rdy1, tx1, busy1, rdy2, tx2, busy2;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  tt_um_uart_transmitter #(.CLK_DIV(16), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .valid_in(valid1),
    .ready_out(rdy1), .tx(tx1), .busy(busy1)
  );

  tt_um_uart_transmitter #(.CLK_DIV(16), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .valid_in(valid2),
    .ready_out(rdy2), .tx(tx2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_tx(input int s);
    return (s != 0) ? tx2 : tx1;
  endfunction
  function automatic logic o_rdy(input int s);
    return (s != 0) ? rdy2 : rdy1;
  endfunction
  function automatic logic o_busy(input int s);
    return (s != 0) ? busy2 : busy1;
  endfunction

  task automatic set_valid(input int s, input logic v);
    if (s != 0) valid2 = v;
    else        valid1 = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string nm, input int s, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s idle busy c%0d", nm, i), o_busy(s), 1'b0);
      chk($sformatf("%s idle tx c%0d", nm, i), o_tx(s), 1'b1);
      chk($sformatf("%s idle ready c%0d", nm, i), o_rdy(s), 1'b1);
    end
  endtask

  // Sends byte d on DUT s and checks tx/ready/busy on every cycle of the frame against
  // a per-cycle expected waveform. gap_* freezes the block with ena=0, poke_k pulses
  // valid while busy, abort_k applies reset mid-frame.
  task automatic frame(input string nm, input int s, input logic [7:0] d, input int nstop,
                       input bit keep_valid, input int gap_k, input int gap_len,
                       input int poke_k, input int abort_k);
    logic q[$];
    int   len;
    int   t;
    for (int i = 0; i < 16; i++) q.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 16; i++) q.push_back(d[b]);
    if (UsePar)
      for (int i = 0; i < 16; i++) q.push_back(^d);
    for (int i = 0; i < nstop * 16; i++) q.push_back(1'b1);
    for (int i = 0; i < gap_len; i++) q.insert(gap_k, q[gap_k-1]);
    len = q.size();

    data_in = d;
    set_valid(s, 1'b1);
    t = 0;
    while (!o_rdy(s) && t < 1000) begin
      tick();
      t++;
    end
    chk({nm, " ready before accept"}, o_rdy(s), 1'b1);
    tick();  // accept edge
    chk({nm, " busy after accept"}, o_busy(s), 1'b1);
    chk({nm, " ready after accept"}, o_rdy(s), 1'b0);
    chk({nm, " tx at accept"}, o_tx(s), 1'b1);
    if (!keep_valid) set_valid(s, 1'b0);
    data_in = ~d;  // must not affect the frame in flight

    for (int k = 1; k <= len; k++) begin
      tick();
      chk($sformatf("%s tx k=%0d", nm, k), o_tx(s), q[k-1]);
      chk($sformatf("%s ready k=%0d", nm, k), o_rdy(s), (k == len));
      chk($sformatf("%s busy k=%0d", nm, k), o_busy(s), (k != len));
      if (k == abort_k) begin
        rst = 1'b1;
        tick();
        chk({nm, " tx after rst"}, o_tx(s), 1'b1);
        chk({nm, " busy after rst"}, o_busy(s), 1'b0);
        chk({nm, " ready during rst"}, o_rdy(s), 1'b0);
        rst = 1'b0;
        #1;
        chk({nm, " ready after rst"}, o_rdy(s), 1'b1);
        return;
      end
      if (gap_len > 0 && k == gap_k) ena = 1'b0;
      if (gap_len > 0 && k == gap_k + gap_len) ena = 1'b1;
      if (k == poke_k) set_valid(s, 1'b1);
      if (k == poke_k + 1) set_valid(s, 1'b0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    ena     = 1'b1;
    valid1  = 1'b0;
    valid2  = 1'b0;
    data_in = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("reset tx1", tx1, 1'b1);
    chk("reset busy1", busy1, 1'b0);
    chk("reset ready1", rdy1, 1'b0);
    chk("reset tx2", tx2, 1'b1);
    chk("reset busy2", busy2, 1'b0);
    valid1 = 1'b1;  // rst wins over valid
    tick();
    chk("rst+valid busy1", busy1, 1'b0);
    valid1 = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready1 after reset", rdy1, 1'b1);
    chk("ready2 after reset", rdy2, 1'b1);

    // Basic frame
    frame("t1_55", 0, 8'h55, 1, 1'b0, 0, 0, -1, -1);
    idle_check("t1", 0, 3);

    // Back-to-back with valid held; data changes mid-frame
    frame("t2_a5", 0, 8'hA5, 1, 1'b1, 0, 0, -1, -1);
    frame("t2_3c", 0, 8'h3C, 1, 1'b0, 0, 0, -1, -1);
    idle_check("t2", 0, 2);

    // Parity-sensitive patterns (odd and even popcount)
    frame("t3_07", 0, 8'h07, 1, 1'b0, 0, 0, -1, -1);
    frame("t3_03", 0, 8'h03, 1, 1'b0, 0, 0, -1, -1);

    // Reset mid-frame, then a clean frame
    frame("t4_abort", 0, 8'h00, 1, 1'b0, 0, 0, -1, 50);
    frame("t4_after", 0, 8'h81, 1, 1'b0, 0, 0, -1, -1);

    // ena low for 10 cycles during data bit 3
    frame("t5_ena", 0, 8'hF0, 1, 1'b0, 70, 10, -1, -1);

    // valid pulse while busy is not queued
    frame("t6_poke", 0, 8'h3A, 1, 1'b0, 0, 0, 40, -1);
    idle_check("t6", 0, 20);

    // ena low in IDLE blocks accepts
    ena = 1'b0;
    valid1 = 1'b1;
    #1;
    chk("ena0 ready1", rdy1, 1'b0);
    repeat (3) tick();
    chk("ena0 busy1", busy1, 1'b0);
    chk("ena0 tx1", tx1, 1'b1);
    valid1 = 1'b0;
    ena = 1'b1;
    #1;
    chk("ena1 ready1", rdy1, 1'b1);

    // Two stop bits
    frame("t6_stop2", 1, 8'hC3, 2, 1'b0, 0, 0, -1, -1);
    idle_check("t6s2", 1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
